// File: rtl/interboard_msg_tx.sv
// interboard_msg_tx: queues {msg_type, number} words and sends each over an 8-bit 4-phase req/ack link.
// Optional even-parity output link_parity when INTERBOARD_TX_PARITY_EN is defined.
module interboard_msg_tx #(
   parameter int FIFO_DEPTH     = 4,
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       send_en,
   input  logic [2:0] send_msg_type,
   input  logic [4:0] send_number,
   output logic       send_full,
   output logic       busy,
   output logic       link_req,
   output logic [7:0] link_data,
`ifdef INTERBOARD_TX_PARITY_EN
   output logic       link_parity,
`endif
   input  logic       link_ack,
   output logic       overflow,
   output logic       timeout_err
);

   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = AW + 1;
   localparam int SCW = $clog2(SETUP_CYCLES + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AW-1:0]  PTR_ONE    = AW'(1'b1);
   localparam logic [CW-1:0]  CNT_ONE    = CW'(1'b1);
   localparam logic [CW-1:0]  FULL_CNT   = CW'(FIFO_DEPTH);
   localparam logic [SCW-1:0] SETUP_LOAD = SCW'(SETUP_CYCLES);
   localparam logic [SCW-1:0] SETUP_ONE  = SCW'(1'b1);
   localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [TCW-1:0] TO_ONE     = TCW'(1'b1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] REQ_HI = 2'd2;
   localparam logic [1:0] REQ_LO = 2'd3;

`ifdef INTERBOARD_TX_PARITY_EN
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
`endif

   logic [7:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]  wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
   logic [CW-1:0]  count_r, count_nxt_s;
   logic           ack_meta_r, ack_sync_r;
   logic [1:0]     state_r, state_nxt_s;
   logic [SCW-1:0] scnt_r, scnt_nxt_s;
   logic [TCW-1:0] tcnt_r, tcnt_nxt_s;
   logic           link_req_r, req_nxt_s;
   logic [7:0]     link_data_r, data_nxt_s;
   logic           full_r, full_nxt_s;
   logic           busy_r, busy_nxt_s;
   logic           overflow_r, timeout_r, timeout_nxt_s;
   logic           push_s, pop_s, overflow_nxt_s;
`ifdef INTERBOARD_TX_PARITY_EN
   logic           link_parity_r;
`endif

   // full is the registered flag from before this edge, so a same-edge pop cannot rescue a word
   assign push_s         = send_en && !full_r && !flush;
   assign overflow_nxt_s = send_en && full_r && !flush;
   assign pop_s          = (state_r == IDLE) && (count_r != '0) && !flush;

   // Queue pointer and occupancy next-state
   always_comb begin
      wptr_nxt_s  = wptr_r;
      rptr_nxt_s  = rptr_r;
      count_nxt_s = count_r;
      if (flush) begin
         wptr_nxt_s  = '0;
         rptr_nxt_s  = '0;
         count_nxt_s = '0;
      end else begin
         if (push_s) wptr_nxt_s = wptr_r + PTR_ONE;
         else        wptr_nxt_s = wptr_r;
         if (pop_s)  rptr_nxt_s = rptr_r + PTR_ONE;
         else        rptr_nxt_s = rptr_r;
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Handshake FSM next-state, plus flags derived from the next queue/FSM state
   always_comb begin
      state_nxt_s   = state_r;
      req_nxt_s     = link_req_r;
      data_nxt_s    = link_data_r;
      scnt_nxt_s    = scnt_r;
      tcnt_nxt_s    = tcnt_r;
      timeout_nxt_s = 1'b0;
      if (flush) begin
         req_nxt_s = 1'b0;
         case (state_r)
            SETUP, REQ_HI: begin
               state_nxt_s = REQ_LO;
               tcnt_nxt_s  = '0;
            end
            default: state_nxt_s = state_r;
         endcase
      end else begin
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  data_nxt_s  = mem_r[rptr_r];
                  scnt_nxt_s  = SETUP_LOAD;
                  state_nxt_s = SETUP;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            SETUP: begin
               // data has been stable SETUP_CYCLES cycles when req appears
               if (scnt_r <= SETUP_ONE) begin
                  req_nxt_s   = 1'b1;
                  tcnt_nxt_s  = '0;
                  state_nxt_s = REQ_HI;
               end else begin
                  scnt_nxt_s  = scnt_r - SETUP_ONE;
               end
            end
            REQ_HI: begin
               if (ack_sync_r) begin
                  req_nxt_s   = 1'b0;
                  tcnt_nxt_s  = '0;
                  state_nxt_s = REQ_LO;
               end else if (tcnt_r == TO_LAST) begin
                  timeout_nxt_s = 1'b1;
                  req_nxt_s     = 1'b0;
                  tcnt_nxt_s    = '0;
                  state_nxt_s   = REQ_LO;
               end else begin
                  tcnt_nxt_s    = tcnt_r + TO_ONE;
               end
            end
            REQ_LO: begin
               if (!ack_sync_r) begin
                  state_nxt_s   = IDLE;
               end else if (tcnt_r == TO_LAST) begin
                  timeout_nxt_s = 1'b1;
                  state_nxt_s   = IDLE;
               end else begin
                  tcnt_nxt_s    = tcnt_r + TO_ONE;
               end
            end
            default: begin
               req_nxt_s   = 1'b0;
               state_nxt_s = IDLE;
            end
         endcase
      end
      full_nxt_s = (count_nxt_s == FULL_CNT);
      busy_nxt_s = (count_nxt_s != '0) || (state_nxt_s != IDLE);
   end

   // Two-flop synchronizer for the asynchronous peer acknowledge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_meta_r <= 1'b0;
         ack_sync_r <= 1'b0;
      end else begin
         ack_meta_r <= link_ack;
         ack_sync_r <= ack_meta_r;
      end
   end

   // Queue storage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      end else if (push_s) begin
         mem_r[wptr_r] <= {send_msg_type, send_number};
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_r      <= '0;
         rptr_r      <= '0;
         count_r     <= '0;
         state_r     <= IDLE;
         scnt_r      <= '0;
         tcnt_r      <= '0;
         link_req_r  <= 1'b0;
         link_data_r <= 8'h00;
         full_r      <= 1'b0;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
         timeout_r   <= 1'b0;
`ifdef INTERBOARD_TX_PARITY_EN
         link_parity_r <= 1'b0;
`endif
      end else begin
         wptr_r      <= wptr_nxt_s;
         rptr_r      <= rptr_nxt_s;
         count_r     <= count_nxt_s;
         state_r     <= state_nxt_s;
         scnt_r      <= scnt_nxt_s;
         tcnt_r      <= tcnt_nxt_s;
         link_req_r  <= req_nxt_s;
         link_data_r <= data_nxt_s;
         full_r      <= full_nxt_s;
         busy_r      <= busy_nxt_s;
         overflow_r  <= overflow_nxt_s;
         timeout_r   <= timeout_nxt_s;
`ifdef INTERBOARD_TX_PARITY_EN
         link_parity_r <= even_parity(data_nxt_s);
`endif
      end
   end

   assign link_req    = link_req_r;
   assign link_data   = link_data_r;
   assign send_full   = full_r;
   assign busy        = busy_r;
   assign overflow    = overflow_r;
   assign timeout_err = timeout_r;
`ifdef INTERBOARD_TX_PARITY_EN
   assign link_parity = link_parity_r;
`endif

endmodule
